// File: rtl/id_ex_hazard_pipe.sv
// ID/EX pipeline register with a load-use hazard scoreboard covering LOAD_LAT cycles.
// Provides immediate extension, a valid bit, downstream hold, and a flush that is held over while EX stalls.
module id_ex_hazard_pipe #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int CTRL_W   = 10,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_id_valid,
    input  logic [31:0]       if_id_instr,
    input  logic [DATA_W-1:0] if_id_pc_next,
    input  logic [CTRL_W-1:0] dec_ctrl,
    input  logic              dec_is_load,
    input  logic              dec_uses_rs,
    input  logic              dec_uses_rt,
    input  logic              dec_zero_ext,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              id_stall,
    output logic              id_ex_valid,
    output logic [CTRL_W-1:0] id_ex_ctrl,
    output logic [DATA_W-1:0] id_ex_rs_data,
    output logic [DATA_W-1:0] id_ex_rt_data,
    output logic [DATA_W-1:0] id_ex_imm,
    output logic [DATA_W-1:0] id_ex_pc_next,
    output logic [REG_AW-1:0] id_ex_rs,
    output logic [REG_AW-1:0] id_ex_rt,
    output logic [REG_AW-1:0] id_ex_rd,
    output logic [4:0]        id_ex_shamt,
    output logic [5:0]        id_ex_funct,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Handshake: ex_hold=1 means EX refuses the ID/EX contents this cycle; the register,
    // scoreboard and counter all freeze, and id_stall tells IF/ID to keep its instruction too.

    logic [REG_AW-1:0] id_rs, id_rt, id_rd;
    logic [DATA_W-1:0] id_imm;
    logic              kill, hazard, sb_match;
    logic              advance, take, bubble;
    logic              flush_pending;
    logic              sb_vld [LOAD_LAT];
    logic [REG_AW-1:0] sb_dst [LOAD_LAT];

    assign id_rs  = REG_AW'(if_id_instr[25:21]);
    assign id_rt  = REG_AW'(if_id_instr[20:16]);
    assign id_rd  = REG_AW'(if_id_instr[15:11]);
    assign id_imm = dec_zero_ext ? DATA_W'(if_id_instr[15:0])
                                 : DATA_W'($signed(if_id_instr[15:0]));

    // Slot i holds a load that entered EX i cycles ago; register 0 is never a real dependency.
    always_comb begin
        sb_match = 1'b0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (sb_vld[i] && (sb_dst[i] != '0) &&
                ((dec_uses_rs && (sb_dst[i] == id_rs)) ||
                 (dec_uses_rt && (sb_dst[i] == id_rt)))) begin
                sb_match = 1'b1;
            end
        end
    end

    assign kill     = flush | flush_pending;
    assign hazard   = if_id_valid & ~kill & sb_match;
    assign id_stall = ex_hold | hazard;
    assign advance  = ~ex_hold;
    assign bubble   = advance & (kill | hazard);
    assign take     = advance & ~kill & ~hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LOAD_LAT; i++) begin
                sb_vld[i] <= 1'b0;
                sb_dst[i] <= '0;
            end
        end else if (advance) begin
            sb_vld[0] <= take & if_id_valid & dec_is_load;
            sb_dst[0] <= (take & if_id_valid & dec_is_load) ? id_rt : '0;
            for (int i = 1; i < LOAD_LAT; i++) begin
                sb_vld[i] <= sb_vld[i-1];
                sb_dst[i] <= sb_dst[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_pending <= 1'b0;
            stall_cnt     <= '0;
        end else if (ex_hold) begin
            flush_pending <= flush_pending | flush;
        end else if (kill) begin
            flush_pending <= 1'b0;
        end else if (hazard && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_valid   <= 1'b0;
            id_ex_ctrl    <= '0;
            id_ex_rs_data <= '0;
            id_ex_rt_data <= '0;
            id_ex_imm     <= '0;
            id_ex_pc_next <= '0;
            id_ex_rs      <= '0;
            id_ex_rt      <= '0;
            id_ex_rd      <= '0;
            id_ex_shamt   <= '0;
            id_ex_funct   <= '0;
        end else if (bubble) begin
            id_ex_valid   <= 1'b0;
            id_ex_ctrl    <= '0;
            id_ex_rs_data <= '0;
            id_ex_rt_data <= '0;
            id_ex_imm     <= '0;
            id_ex_pc_next <= '0;
            id_ex_rs      <= '0;
            id_ex_rt      <= '0;
            id_ex_rd      <= '0;
            id_ex_shamt   <= '0;
            id_ex_funct   <= '0;
        end else if (take) begin
            id_ex_valid   <= if_id_valid;
            id_ex_ctrl    <= if_id_valid ? dec_ctrl : '0;
            id_ex_rs_data <= rs_data;
            id_ex_rt_data <= rt_data;
            id_ex_imm     <= id_imm;
            id_ex_pc_next <= if_id_pc_next;
            id_ex_rs      <= id_rs;
            id_ex_rt      <= id_rt;
            id_ex_rd      <= id_rd;
            id_ex_shamt   <= if_id_instr[10:6];
            id_ex_funct   <= if_id_instr[5:0];
        end
    end

endmodule

// File: tb/tb_id_ex_hazard_pipe.sv
// Bench for id_ex_hazard_pipe: dut_a has LOAD_LAT=1 and a 2-bit counter, dut_b has LOAD_LAT=3.
// Both share one input stream; each directed phase checks only the instance it targets.
module tb_id_ex_hazard_pipe;
    localparam int OW = 1 + 10 + 32 * 4 + 5 * 3 + 5 + 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_next;
    logic [9:0]  dec_ctrl;
    logic        dec_is_load, dec_uses_rs, dec_uses_rt, dec_zero_ext;
    logic [31:0] rs_data, rt_data;
    logic        flush, ex_hold;

    logic        stall_a, v_a, stall_b, v_b;
    logic [9:0]  ctrl_a, ctrl_b;
    logic [31:0] rsd_a, rtd_a, imm_a, pcn_a, rsd_b, rtd_b, imm_b, pcn_b;
    logic [4:0]  rs_a, rt_a, rd_a, sh_a, rs_b, rt_b, rd_b, sh_b;
    logic [5:0]  fn_a, fn_b;
    logic [1:0]  cnt_a;
    logic [15:0] cnt_b;
    logic [OW-1:0] obs_a, obs_b;

    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] last_exp;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    id_ex_hazard_pipe #(.DATA_W(32), .REG_AW(5), .CTRL_W(10), .LOAD_LAT(1), .CNT_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc_next(if_id_pc_next), .dec_ctrl(dec_ctrl), .dec_is_load(dec_is_load),
        .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt), .dec_zero_ext(dec_zero_ext),
        .rs_data(rs_data), .rt_data(rt_data), .flush(flush), .ex_hold(ex_hold),
        .id_stall(stall_a), .id_ex_valid(v_a), .id_ex_ctrl(ctrl_a), .id_ex_rs_data(rsd_a),
        .id_ex_rt_data(rtd_a), .id_ex_imm(imm_a), .id_ex_pc_next(pcn_a), .id_ex_rs(rs_a),
        .id_ex_rt(rt_a), .id_ex_rd(rd_a), .id_ex_shamt(sh_a), .id_ex_funct(fn_a),
        .stall_cnt(cnt_a)
    );

    id_ex_hazard_pipe #(.DATA_W(32), .REG_AW(5), .CTRL_W(10), .LOAD_LAT(3), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc_next(if_id_pc_next), .dec_ctrl(dec_ctrl), .dec_is_load(dec_is_load),
        .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt), .dec_zero_ext(dec_zero_ext),
        .rs_data(rs_data), .rt_data(rt_data), .flush(flush), .ex_hold(ex_hold),
        .id_stall(stall_b), .id_ex_valid(v_b), .id_ex_ctrl(ctrl_b), .id_ex_rs_data(rsd_b),
        .id_ex_rt_data(rtd_b), .id_ex_imm(imm_b), .id_ex_pc_next(pcn_b), .id_ex_rs(rs_b),
        .id_ex_rt(rt_b), .id_ex_rd(rd_b), .id_ex_shamt(sh_b), .id_ex_funct(fn_b),
        .stall_cnt(cnt_b)
    );

    assign obs_a = {v_a, ctrl_a, rsd_a, rtd_a, imm_a, pcn_a, rs_a, rt_a, rd_a, sh_a, fn_a};
    assign obs_b = {v_b, ctrl_b, rsd_b, rtd_b, imm_b, pcn_b, rs_b, rt_b, rd_b, sh_b, fn_b};

    function automatic logic [31:0] enc_add(input logic [4:0] rd, rs, rt);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] enc_lw(input logic [4:0] rt);
        return {6'h23, 5'd29, rt, 16'h0010};
    endfunction

    // Expected ID/EX image when the ID instruction is captured.
    function automatic logic [OW-1:0] capture_image();
        logic [31:0] imm;
        imm = dec_zero_ext ? {16'h0000, if_id_instr[15:0]}
                           : {{16{if_id_instr[15]}}, if_id_instr[15:0]};
        return {if_id_valid, if_id_valid ? dec_ctrl : 10'h000, rs_data, rt_data, imm,
                if_id_pc_next, if_id_instr[25:21], if_id_instr[20:16], if_id_instr[15:11],
                if_id_instr[10:6], if_id_instr[5:0]};
    endfunction

    task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One ID cycle: drive, check id_stall mid-cycle, queue the expected ID/EX image,
    // then pop and compare it one clock later.
    task automatic step(input bit sel, input logic v, input logic [31:0] instr,
                        input logic ld, input logic urs, input logic urt, input logic zext,
                        input logic fl, input logic hold, input logic exp_stall,
                        input logic exp_bubble, input string tag);
        logic [OW-1:0] e;
        if_id_valid   = v;
        if_id_instr   = instr;
        dec_is_load   = ld;
        dec_uses_rs   = urs;
        dec_uses_rt   = urt;
        dec_zero_ext  = zext;
        flush         = fl;
        ex_hold       = hold;
        dec_ctrl      = 10'($urandom_range(1, 1023));
        rs_data       = $urandom;
        rt_data       = $urandom;
        if_id_pc_next = $urandom;
        #3;
        chk({tag, "_stall"}, OW'(sel ? stall_b : stall_a), OW'(exp_stall));
        if (hold)            e = last_exp;
        else if (exp_bubble) e = '0;
        else                 e = capture_image();
        exp_q.push_back(e);
        last_exp = e;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, "_idex"}, sel ? obs_b : obs_a, e);
    endtask

    task automatic do_lw(input bit sel, input logic [4:0] rt, input string tag);
        step(sel, 1'b1, enc_lw(rt), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic do_add(input bit sel, input logic [4:0] rd, rs, rt,
                          input logic exp_stall, input string tag);
        step(sel, 1'b1, enc_add(rd, rs, rt), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
             exp_stall, exp_stall, tag);
    endtask

    task automatic idle_inputs();
        if_id_valid = 0; if_id_instr = 0; if_id_pc_next = 0; dec_ctrl = 0;
        dec_is_load = 0; dec_uses_rs = 0; dec_uses_rt = 0; dec_zero_ext = 0;
        rs_data = 0; rt_data = 0; flush = 0; ex_hold = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_exp = '0;
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        last_exp = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_obs_a", obs_a, '0);
        chk("rst_obs_b", obs_b, '0);
        chk("rst_cnt_a", OW'(cnt_a), '0);
        chk("rst_cnt_b", OW'(cnt_b), '0);
        chk("rst_stall_a", OW'(stall_a), '0);
        rst_n = 1'b1;

        // LOAD_LAT=1: one bubble for an immediately dependent add
        do_lw(1'b0, 5'd3, "a_lw3");
        do_add(1'b0, 5'd4, 5'd3, 5'd5, 1'b1, "a_dep_bub");
        do_add(1'b0, 5'd4, 5'd3, 5'd5, 1'b0, "a_dep_go");
        chk("a_cnt_1", OW'(cnt_a), OW'(1));

        // invalid load never enters the scoreboard; ctrl forced to 0
        step(1'b0, 1'b0, enc_lw(5'd3), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "a_inv_lw");
        do_add(1'b0, 5'd4, 5'd3, 5'd3, 1'b0, "a_after_inv");
        do_lw(1'b0, 5'd6, "a_lw6");
        do_add(1'b0, 5'd7, 5'd8, 5'd9, 1'b0, "a_indep");
        do_lw(1'b0, 5'd0, "a_lw0");
        do_add(1'b0, 5'd1, 5'd0, 5'd0, 1'b0, "a_r0");

        // immediate extension
        step(1'b0, 1'b1, {6'h08, 5'd1, 5'd2, 16'h8001}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b0, 1'b0, "a_sext");
        chk("a_imm_sext", OW'(imm_a), OW'(32'hFFFF8001));
        step(1'b0, 1'b1, {6'h0D, 5'd1, 5'd2, 16'h8001}, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
             1'b0, 1'b0, "a_zext");
        chk("a_imm_zext", OW'(imm_a), OW'(32'h00008001));

        // flush masks a hazard and yields a bubble
        do_lw(1'b0, 5'd3, "a_lw3_f");
        step(1'b0, 1'b1, enc_add(5'd4, 5'd3, 5'd3), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
             1'b0, 1'b1, "a_flush");
        do_add(1'b0, 5'd4, 5'd3, 5'd3, 1'b0, "a_post_flush");
        chk("a_cnt_still_1", OW'(cnt_a), OW'(1));

        // flush during a 3-cycle hold: contents held, then one bubble, then normal capture
        do_add(1'b0, 5'd10, 5'd11, 5'd12, 1'b0, "a_i1");
        step(1'b0, 1'b1, enc_add(5'd13, 5'd1, 5'd2), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
             1'b1, 1'b0, "a_hold1");
        step(1'b0, 1'b1, enc_add(5'd13, 5'd1, 5'd2), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
             1'b1, 1'b0, "a_hold2");
        step(1'b0, 1'b1, enc_add(5'd13, 5'd1, 5'd2), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
             1'b1, 1'b0, "a_hold3");
        step(1'b0, 1'b1, enc_lw(5'd5), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
             "a_pend_bub");
        do_add(1'b0, 5'd6, 5'd5, 5'd5, 1'b0, "a_after_pend");

        // asynchronous reset with a load in flight
        do_lw(1'b0, 5'd3, "a_lw3_r");
        if_id_valid = 1'b1; if_id_instr = enc_add(5'd4, 5'd3, 5'd5);
        dec_is_load = 1'b0; dec_uses_rs = 1'b1; dec_uses_rt = 1'b1;
        #2;
        chk("a_pre_rst_stall", OW'(stall_a), OW'(1));
        rst_n = 1'b0;
        #1;
        chk("a_async_obs", obs_a, '0);
        chk("a_async_cnt", OW'(cnt_a), '0);
        chk("a_async_stall", OW'(stall_a), '0);
        rst_n = 1'b1;
        last_exp = capture_image();
        @(posedge clk);
        #1;
        chk("a_post_rst_cap", obs_a, last_exp);
        do_add(1'b0, 5'd4, 5'd3, 5'd5, 1'b0, "a_post_rst_add");

        // counter saturation on the 2-bit instance
        do_reset();
        for (int k = 0; k < 5; k++) begin
            do_lw(1'b0, 5'd3, "a_sat_lw");
            do_add(1'b0, 5'd4, 5'd3, 5'd3, 1'b1, "a_sat_bub");
            do_add(1'b0, 5'd4, 5'd3, 5'd3, 1'b0, "a_sat_go");
            if (k == 1) chk("a_sat_cnt2", OW'(cnt_a), OW'(2));
        end
        chk("a_sat_cnt3", OW'(cnt_a), OW'(3));

        // LOAD_LAT=3: one independent instruction leaves two bubbles
        do_reset();
        do_lw(1'b1, 5'd7, "b_lw7");
        step(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "b_nop");
        do_add(1'b1, 5'd8, 5'd7, 5'd7, 1'b1, "b_bub1");
        do_add(1'b1, 5'd8, 5'd7, 5'd7, 1'b1, "b_bub2");
        do_add(1'b1, 5'd8, 5'd7, 5'd7, 1'b0, "b_go");
        chk("b_cnt_2", OW'(cnt_b), OW'(2));
        do_lw(1'b1, 5'd0, "b_lw0");
        do_add(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, "b_r0");
        do_lw(1'b1, 5'd9, "b_lw9");
        for (int k = 0; k < 3; k++) do_add(1'b1, 5'd10, 5'd9, 5'd2, 1'b1, "b_imm_bub");
        do_add(1'b1, 5'd10, 5'd9, 5'd2, 1'b0, "b_imm_go");
        chk("b_cnt_5", OW'(cnt_b), OW'(5));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/id_ex_hazard_pipe.md
Name: id_ex_hazard_pipe

Overview:
Parametrised decode-to-execute pipeline register with an integrated load-use hazard scoreboard. Sits between the IF/ID register, the control decoder and the register file on one side and the EX stage on the other. It generalises the single-bubble load-use stall to a configurable load latency, exempts register 0 from hazard checks, and adds selectable immediate extension. It also adds a valid bit, downstream hold and a flush that is safe under hold.

Parameters:
DATA_W, 32, datapath and PC width; must be at least 16
REG_AW, 5, register address width
CTRL_W, 10, width of the packed control bundle from the decoder
LOAD_LAT, 1, bubbles required between a load and a dependent instruction; range 1..4
CNT_W, 16, width of the stall performance counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
if_id_valid  in  1  instruction in ID is valid
if_id_instr  in  32  instruction word
if_id_pc_next  in  DATA_W  PC+4 of the ID instruction
dec_ctrl  in  CTRL_W  decoded control bundle
dec_is_load  in  1  ID instruction is a load
dec_uses_rs  in  1  ID instruction reads rs
dec_uses_rt  in  1  ID instruction reads rt
dec_zero_ext  in  1  1 = zero-extend the immediate, 0 = sign-extend it
rs_data  in  DATA_W  register file read port A
rt_data  in  DATA_W  register file read port B
flush  in  1  kill the instruction currently in ID
ex_hold  in  1  EX stage cannot accept; ID/EX must hold
id_stall  out  1  freeze PC and IF/ID
id_ex_valid  out  1  valid bit of the ID/EX register
id_ex_ctrl  out  CTRL_W  registered control bundle
id_ex_rs_data  out  DATA_W  registered rs operand
id_ex_rt_data  out  DATA_W  registered rt operand
id_ex_imm  out  DATA_W  registered extended immediate
id_ex_pc_next  out  DATA_W  registered PC+4
id_ex_rs, id_ex_rt, id_ex_rd  out  REG_AW each  registered register fields (instr[25:21], [20:16], [15:11])
id_ex_shamt  out  5  registered instr[10:6]
id_ex_funct  out  6  registered instr[5:0]
stall_cnt  out  CNT_W  saturating count of load-use bubble cycles

Behaviour:
- Reset (asynchronous, rst_n low): every output register, every scoreboard slot, flush_pending and stall_cnt go to 0.
- Immediate extension:
  - Zero-extend: id_ex_imm = {(DATA_W-16) zeros, instr[15:0]}.
  - Sign-extend: the upper bits replicate instr[15].
- Scoreboard: LOAD_LAT slots, each holding a valid bit and a REG_AW destination.
  - Shifts only on an advance cycle (ex_hold=0).
  - Slot0 takes {1, rt} when the accepted instruction is a valid load; otherwise slot0 takes empty.
  - Slot i takes slot i-1; the last slot drops out.
  - On a hold cycle the scoreboard is frozen.
- Hazard:
  - hazard = if_id_valid & ~kill & (any valid slot whose dest ≠ 0 and (dest==rs & dec_uses_rs or dest==rt & dec_uses_rt)).
  - kill = flush | flush_pending.
- id_stall = ex_hold | hazard. This is combinational with no added cycle.
- Per cycle, in priority order:
  1. ex_hold=1: all ID/EX registers hold. If flush=1, set flush_pending.
  2. kill=1: load a bubble (valid=0, ctrl=0, all fields 0) and clear flush_pending.
  3. hazard=1: load a bubble and increment stall_cnt, saturating at all ones.
  4. Otherwise: capture the ID instruction, with valid = if_id_valid. If if_id_valid=0, ctrl is forced to 0.
- Bubble cycles shift an empty entry into slot0.
- Latency: one clock from ID inputs to ID/EX outputs.
- LOAD_LAT=1 gives exactly one bubble for an immediately dependent instruction.
- LOAD_LAT=N gives N-k bubbles when k independent instructions separate the load and its consumer; there are none when k ≥ N.
- Register 0 never causes a stall.

Test Plan:
- Reset mid-stream: lw $3 in flight, assert rst_n=0 -> all outputs 0 asynchronously, slots empty, next add $4,$3 proceeds with no stall.
- LOAD_LAT=1: lw $3; add $4,$3,$5 -> id_stall high for exactly 1 cycle, one id_ex_valid=0 bubble, stall_cnt=1.
- LOAD_LAT=3: lw $7; nop; add $8,$7,$7 -> exactly 2 bubbles, stall_cnt=2. lw $0; add $1,$0,$0 -> 0 bubbles.
- Flush during hold: ex_hold=1 for 3 cycles with flush pulsed in cycle 1 -> ID/EX unchanged during hold; first advance cycle produces a bubble; the following instruction captures normally.
- Extension: instr[15:0]=16'h8001 -> id_ex_imm=32'hFFFF8001 with dec_zero_ext=0, 32'h00008001 with dec_zero_ext=1.
- Saturation: CNT_W=2, force 5 load-use stalls -> stall_cnt sticks at 3.
